// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern blocks: pattern modes, bounce
// direction and blink phase.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ALL_ON = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } phase_e;

endpackage

// File: rtl/tick_gen.sv
// Divide-by-DIV prescaler; tick is high for one cycle every DIV cycles.
// Ports: clk, rst (sync, active-high), clr (restart count at 0), tick.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: all-on / blink / chase / bounce, PWM-gated.
// Ports: clk, rst (sync, active-high), mode[1:0], brightness, leds (registered).
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int CLK_HZ   = 12000000,
    parameter int STEP_HZ  = 4,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [NUM_LEDS-1:0] leds
);

    localparam int STEP_DIV = CLK_HZ / STEP_HZ;
    localparam logic [NUM_LEDS-1:0] ONE = NUM_LEDS'(1);

    mode_e                mode_q;
    dir_e                 dir_q, dir_d;
    phase_e               blink_q, blink_d;
    logic [NUM_LEDS-1:0]  pattern_q, pattern_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q;
    logic [NUM_LEDS-1:0]  leds_q;
    logic [NUM_LEDS-1:0]  raw;
    logic                 mode_chg;
    logic                 step_tick;
    logic                 pwm_on;

    assign mode_chg = (mode != mode_q);
    assign pwm_on   = (pwm_cnt_q <= brightness);
    assign leds     = leds_q;

    // A mode change restarts the prescaler so the first step is a full period.
    tick_gen #(
        .DIV(STEP_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (mode_chg),
        .tick(step_tick)
    );

    always_comb begin
        raw = '0;
        unique case (mode_q)
            MODE_ALL_ON: raw = '1;
            MODE_BLINK:  raw = {NUM_LEDS{blink_q == PHASE_ON}};
            MODE_CHASE:  raw = pattern_q;
            MODE_BOUNCE: raw = pattern_q;
            default:     raw = '0;
        endcase
    end

    always_comb begin
        pattern_d = pattern_q;
        dir_d     = dir_q;
        blink_d   = blink_q;
        if (mode_chg) begin
            pattern_d = ONE;
            dir_d     = DIR_UP;
            blink_d   = PHASE_ON;
        end else if (step_tick) begin
            blink_d = (blink_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            if (mode_q == MODE_CHASE) begin
                // Rotate left; for a single LED this leaves bit0 in place.
                pattern_d = (pattern_q << 1) | (pattern_q >> (NUM_LEDS - 1));
            end else if (mode_q == MODE_BOUNCE && NUM_LEDS > 1) begin
                // Turn around on reaching an end so endpoints show for one step.
                if (dir_q == DIR_UP) begin
                    if (pattern_q[NUM_LEDS-1]) begin
                        dir_d     = DIR_DOWN;
                        pattern_d = pattern_q >> 1;
                    end else begin
                        pattern_d = pattern_q << 1;
                    end
                end else begin
                    if (pattern_q[0]) begin
                        dir_d     = DIR_UP;
                        pattern_d = pattern_q << 1;
                    end else begin
                        pattern_d = pattern_q >> 1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_ALL_ON;
            dir_q     <= DIR_UP;
            blink_q   <= PHASE_ON;
            pattern_q <= ONE;
            pwm_cnt_q <= '0;
            leds_q    <= '0;
        end else begin
            mode_q    <= mode_e'(mode);
            dir_q     <= dir_d;
            blink_q   <= blink_d;
            pattern_q <= pattern_d;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            leds_q    <= raw & {NUM_LEDS{pwm_on}};
        end
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised successor to the static all-on LED driver for the iCE40-HX8K board. Drives NUM_LEDS outputs with a selectable pattern: all-on, blink, chase, or bounce. A global PWM brightness gate applies to every pattern. Sits at top level between board clock/reset and the LED pins; mode and brightness come from switches or a control register.

Parameters:
NUM_LEDS, 8, number of LED channels (>=1)
CLK_HZ, 12000000, input clock frequency in Hz
STEP_HZ, 4, pattern step rate in Hz; STEP_DIV = CLK_HZ/STEP_HZ (integer, >=2)
PWM_BITS, 4, brightness/PWM counter width (>=1)

Ports:
clk  input  1  board clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
mode  input  2  pattern select: 0 ALL_ON, 1 BLINK, 2 CHASE, 3 BOUNCE
brightness  input  PWM_BITS  duty select: duty = (brightness+1)/2^PWM_BITS
leds  output  NUM_LEDS  registered LED drive, 1 = lit

Behaviour:
- Single clock domain, clk. Reset is synchronous, active-high (rst): sampled only at the rising edge of clk.
- Reset values: leds=0, prescaler=0, pwm_cnt=0, pattern=one-hot bit0, dir=UP, blink_phase=ON, mode_q=0.
- Prescaler: counts 0..STEP_DIV-1 and wraps. step_tick=1 for one cycle when prescaler==STEP_DIV-1.
- PWM: pwm_cnt is free-running PWM_BITS wide and wraps at 2^PWM_BITS-1 -> 0. pwm_on = (pwm_cnt <= brightness). brightness = all-ones gives 100% duty; brightness = 0 gives 1/2^PWM_BITS duty.
- Raw pattern per mode:
  - ALL_ON: all ones.
  - BLINK: all ones when blink_phase=ON, else zero. blink_phase toggles on each step_tick.
  - CHASE: one-hot, rotates toward MSB on each step_tick. bit NUM_LEDS-1 wraps to bit0.
  - BOUNCE: one-hot, moves in dir on each step_tick. At bit NUM_LEDS-1 with dir=UP, dir becomes DOWN and the next step is bit NUM_LEDS-2. Symmetric at bit0. Endpoints are never held for two steps. Sequence for N=4: 0,1,2,3,2,1,0,1...
  - NUM_LEDS=1: CHASE and BOUNCE stay on bit0.
- Output: leds <= raw_pattern & {NUM_LEDS{pwm_on}}, registered. One cycle latency from the pattern/pwm_cnt state to the pins.
- Mode change: mode_q registers mode. On any cycle where mode != mode_q, the next cycle has:
  - pattern=bit0, dir=UP, blink_phase=ON, prescaler=0, so the first step is a full STEP_DIV after the change.
  - pwm_cnt is unaffected.
  - The change takes priority over a step_tick in the same cycle.
- Brightness changes take effect on pwm_on in the same cycle and on leds the next cycle. No restart.
- Reset mid-pattern: all state returns to reset values on the next edge. leds=0 for exactly the reset cycle(s), then the pattern resumes from bit0.
- Width rule: prescaler width = $clog2(STEP_DIV), minimum 1. No overflow past STEP_DIV-1.

Decomposition:
- Shared package/header led_pkg: mode encodings MODE_ALL_ON=2'd0, MODE_BLINK=2'd1, MODE_CHASE=2'd2, MODE_BOUNCE=2'd3; DIR_UP/DIR_DOWN constants.
- One sub-module, tick_gen (params DIV; ports clk, rst, clr, tick). Reused by later board blocks.
- PWM compare and pattern FSM stay inline in led_pattern_gen.

Test Plan:
(sim params NUM_LEDS=4, CLK_HZ=16, STEP_HZ=2 -> STEP_DIV=8, PWM_BITS=2)
1. rst=1 for 3 cycles, mode=0, brightness=3 -> leds=0 during reset. leds=4'b1111 from the 2nd cycle after rst falls and on every cycle after.
2. mode=2, brightness=3, run 40 cycles -> leds steps 0001,0010,0100,1000,0001 every 8 cycles. First change occurs 8 cycles after the pattern start.
3. mode=3, brightness=3 -> step sequence 0001,0010,0100,1000,0100,0010,0001,0010. No repeated endpoint.
4. mode=0, brightness=1 -> leds=1111 for 2 of every 4 cycles, 0000 for the other 2. brightness=0 gives 1 of 4 cycles lit.
5. mode=2, advance to 0100, switch to mode=1 in the same cycle as a step_tick -> pattern restarts with blink_phase=ON: leds=1111 for 8 cycles, then 0000 for 8 cycles.
6. mode=3 at 1000, assert rst for 1 cycle mid-step -> leds=0 for that cycle. The pattern restarts at 0001 with dir=UP and the next step occurs 8 cycles after reset release.
